// File: rtl/s2mm_packer.sv
// Packs a free-running valid-only sample stream into fixed-length AXI-Stream packets for a DMA S2MM port.
// Optional header beat per packet when S2MM_PACKER_HDR_EN is defined (requires DATA_WIDTH >= 64).
module s2mm_packer #(
  parameter int DATA_WIDTH = 64,
  parameter int FIFO_DEPTH = 16,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                    sys_clk,
  input  logic                    perif_rst_n,
  input  logic                    cfg_enable,
  input  logic [LEN_WIDTH-1:0]    cfg_pkt_len,
  input  logic [DATA_WIDTH-1:0]   s_data,
  input  logic                    s_valid,
  output logic [DATA_WIDTH-1:0]   m_axis_tdata,
  output logic [DATA_WIDTH/8-1:0] m_axis_tkeep,
  output logic                    m_axis_tvalid,
  input  logic                    m_axis_tready,
  output logic                    m_axis_tlast,
  output logic [31:0]             stat_pkt_cnt,
  output logic [31:0]             stat_drop_cnt,
  output logic                    busy
);
  // AXI-Stream master: a beat moves on tvalid & tready; once tvalid is high,
  // tdata/tlast hold until that transfer and tvalid only falls after one (or on reset).
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0]          PTR_ONE = 1;
  localparam logic [LEN_WIDTH-1:0] LEN_ONE = 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   mem_q [FIFO_DEPTH];
  logic [AW:0]             wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LEN_WIDTH-1:0]    len_q, len_d, beat_cnt_q, beat_cnt_d;
  logic [31:0]             pkt_cnt_q, pkt_cnt_d, drop_cnt_q, drop_cnt_d;
  logic                    hdr_sent_q, hdr_sent_d;

  logic                    fifo_empty, fifo_full, pkt_open, is_last;
  logic                    tvalid_c, tlast_c, hdr_beat, rd_en, wr_en, drop, flush;
  logic [DATA_WIDTH-1:0]   tdata_c, fifo_head;
  logic [LEN_WIDTH-1:0]    cfg_len_eff;

  assign fifo_empty  = (wr_ptr_q == rd_ptr_q);
  assign fifo_full   = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign fifo_head   = mem_q[rd_ptr_q[AW-1:0]];
  assign cfg_len_eff = (cfg_pkt_len == '0) ? LEN_ONE : cfg_pkt_len;
  // A packet is open once any beat of it (header included) has been accepted.
  assign pkt_open    = (beat_cnt_q != '0) || hdr_sent_q;
  assign is_last     = (beat_cnt_q == (len_q - LEN_ONE));

`ifdef S2MM_PACKER_HDR_EN
  logic [DATA_WIDTH-1:0] hdr_word;
  always_comb begin
    hdr_word        = '0;
    hdr_word[31:0]  = pkt_cnt_q;
    hdr_word[47:32] = 16'(len_q);
    hdr_word[63:48] = 16'hA5A5;
  end
`endif

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    len_d      = len_q;
    beat_cnt_d = beat_cnt_q;
    pkt_cnt_d  = pkt_cnt_q;
    drop_cnt_d = drop_cnt_q;
    hdr_sent_d = hdr_sent_q;
    tvalid_c   = 1'b0;
    tdata_c    = '0;
    tlast_c    = 1'b0;
    hdr_beat   = 1'b0;
    rd_en      = 1'b0;
    wr_en      = 1'b0;
    drop       = 1'b0;
    flush      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cfg_enable) begin
          state_d = RUN;
          len_d   = cfg_len_eff;
        end
      end
      RUN: begin
        if (!fifo_empty) begin
          tvalid_c = 1'b1;
`ifdef S2MM_PACKER_HDR_EN
          if (!pkt_open) begin
            hdr_beat = 1'b1;
            tdata_c  = hdr_word;
          end else begin
            tdata_c = fifo_head;
            tlast_c = is_last;
          end
`else
          tdata_c = fifo_head;
          tlast_c = is_last;
`endif
        end
        rd_en = tvalid_c && m_axis_tready && !hdr_beat;
        wr_en = s_valid && (!fifo_full || rd_en);
        drop  = s_valid && fifo_full && !rd_en;
        // Leaving RUN waits out a stalled beat so it is never withdrawn by the flush.
        if (!cfg_enable && !(tvalid_c && !m_axis_tready)) state_d = DRAIN;
      end
      DRAIN: begin
        if (pkt_open) begin
          tvalid_c = 1'b1;
          tlast_c  = is_last;
          if (!fifo_empty) begin
            tdata_c = fifo_head;
            rd_en   = m_axis_tready;
          end
        end else begin
          flush   = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (tvalid_c && m_axis_tready) begin
      if (hdr_beat) begin
        hdr_sent_d = 1'b1;
      end else if (tlast_c) begin
        beat_cnt_d = '0;
        pkt_cnt_d  = pkt_cnt_q + 32'd1;
        len_d      = cfg_len_eff;
        hdr_sent_d = 1'b0;
      end else begin
        beat_cnt_d = beat_cnt_q + LEN_ONE;
      end
    end
    if (rd_en) rd_ptr_d = rd_ptr_q + PTR_ONE;
    if (flush) rd_ptr_d = wr_ptr_q;
    if (wr_en) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (drop && (drop_cnt_q != 32'hFFFF_FFFF)) drop_cnt_d = drop_cnt_q + 32'd1;
  end

  always_ff @(posedge sys_clk or negedge perif_rst_n) begin
    if (!perif_rst_n) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      len_q      <= LEN_ONE;
      beat_cnt_q <= '0;
      pkt_cnt_q  <= '0;
      drop_cnt_q <= '0;
      hdr_sent_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      len_q      <= len_d;
      beat_cnt_q <= beat_cnt_d;
      pkt_cnt_q  <= pkt_cnt_d;
      drop_cnt_q <= drop_cnt_d;
      hdr_sent_q <= hdr_sent_d;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= s_data;
  end

  assign m_axis_tdata  = tdata_c;
  assign m_axis_tkeep  = '1;
  assign m_axis_tvalid = tvalid_c;
  assign m_axis_tlast  = tlast_c;
  assign stat_pkt_cnt  = pkt_cnt_q;
  assign stat_drop_cnt = drop_cnt_q;
  assign busy          = (state_q != IDLE);
endmodule
